// File: rtl/psum_add_arbiter_if.sv
// Requester/response bundle for the shared partial-sum adder.
// The slave modport is the arbiter side; the master modport is the PE/consumer side.
interface psum_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_W-1:0]         resp_sum;
  logic                      resp_carry;
  logic [ID_W-1:0]           resp_id;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_carry, resp_id
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_carry, resp_id
  );
endinterface

// File: rtl/psum_add_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// One grant per cycle; result held in a single register until drained.
module psum_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  psum_add_arbiter_if.slave   bus,
  output logic [15:0]         o_grant_cnt
);

  logic [ID_W-1:0]    r_ptr;
  logic               r_full;
  logic [DATA_W-1:0]  r_sum;
  logic               r_carry;
  logic [ID_W-1:0]    r_id;
  logic [15:0]        r_grant_cnt;

  logic               w_found;
  logic [ID_W-1:0]    w_gnt;
  logic [ID_W-1:0]    w_cand;
  logic               w_can_accept;
  logic               w_fire;
  logic [NUM_REQ-1:0] w_ready;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic [DATA_W:0]    w_sum;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return ID_W'(s);
  endfunction

  // Round-robin search from r_ptr, grant decode and operand selection.
  always_comb begin
    w_found      = 1'b0;
    w_gnt        = {ID_W{1'b0}};
    w_cand       = {ID_W{1'b0}};
    w_ready      = {NUM_REQ{1'b0}};
    w_can_accept = !r_full || bus.resp_ready;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = wrap_idx(r_ptr, k);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
    // rst gates ready so no handshake can complete while reset is held
    w_fire = w_found && w_can_accept && !rst;
    if (w_fire) begin
      w_ready[w_gnt] = 1'b1;
    end else begin
      w_ready = {NUM_REQ{1'b0}};
    end
    w_a   = bus.req_a[w_gnt*DATA_W +: DATA_W];
    w_b   = bus.req_b[w_gnt*DATA_W +: DATA_W];
    w_sum = {1'b0, w_a} + {1'b0, w_b};
  end

  // Result register, full flag, rotation pointer and grant counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= {ID_W{1'b0}};
      r_full      <= 1'b0;
      r_sum       <= {DATA_W{1'b0}};
      r_carry     <= 1'b0;
      r_id        <= {ID_W{1'b0}};
      r_grant_cnt <= 16'd0;
    end else if (w_fire) begin
      r_sum       <= w_sum[DATA_W-1:0];
      r_carry     <= w_sum[DATA_W];
      r_id        <= w_gnt;
      r_full      <= 1'b1;
      r_ptr       <= wrap_idx(w_gnt, 1);
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end else if (r_full && bus.resp_ready) begin
      r_full      <= 1'b0;
    end else begin
      r_full      <= r_full;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_full;
  assign bus.resp_sum   = r_sum;
  assign bus.resp_carry = r_carry;
  assign bus.resp_id    = r_id;
  assign o_grant_cnt    = r_grant_cnt;

endmodule
